riscvboy_ifq: RTL

Parametrised instruction fetch queue for the riscvBoy core. It sits between the synchronous instruction memory and the decode stage. It issues sequential fetches ahead of decode and buffers up to DEPTH instruction/PC pairs. It decouples decode stalls from memory reads with a valid/ready handshake and flushes all buffered and in-flight fetches on an EXU jump.

---
 rtl/riscvboy_ifq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/riscvboy_ifq.sv
// riscvboy_ifq: instruction fetch queue between synchronous instruction memory and decode.
// Issues sequential fetches ahead of decode, buffers up to DEPTH instr/PC pairs,
// and drops all buffered and in-flight fetches on an EXU jump.
module riscvboy_ifq #(
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     INS_W     = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [INS_W-1:0] NOP_INSTR = INS_W'(32'h0000_0013)
) (
    input  logic                     clk_sys,
    input  logic                     rst_sys,
    output logic                     o_instr_ren,
    output logic [PC_W-1:0]          o_instr_raddr,
    input  logic [INS_W-1:0]         i_instr_dina,
    input  logic                     i_jump_en,
    input  logic [PC_W-1:0]          i_jump_addr,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [INS_W-1:0]         o_instr,
    output logic [PC_W-1:0]          o_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [PC_W-1:0]  r_fetch_pc;
    logic [PC_W-1:0]  r_inflight_pc;
    logic             r_inflight;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [PC_W-1:0]  r_pc_mem  [DEPTH];
    logic [INS_W-1:0] r_ins_mem [DEPTH];

    logic [OCC_W-1:0] w_occupied;
    logic             w_ren;
    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;
    logic [PC_W-1:0]  w_jump_target;

    logic [PC_W-1:0]  w_fetch_pc_nxt;
    logic [PC_W-1:0]  w_inflight_pc_nxt;
    logic             w_inflight_nxt;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    // Issue/push/pop qualifiers; issue ignores a same-cycle pop so a slot is always reserved
    always_comb begin
        w_nonempty    = (r_count != '0);
        w_occupied    = OCC_W'(r_count) + OCC_W'(r_inflight);
        w_ren         = !rst_sys && !i_jump_en && (w_occupied < OCC_W'(DEPTH));
        w_push        = r_inflight && !i_jump_en && !rst_sys;
        w_pop         = w_nonempty && i_ready && !i_jump_en;
        w_jump_target = i_jump_addr & ~PC_W'(3);
    end

    // Next-state for fetch PC, in-flight tracking, pointers and occupancy
    always_comb begin
        w_fetch_pc_nxt    = r_fetch_pc;
        w_inflight_pc_nxt = r_inflight_pc;
        w_inflight_nxt    = 1'b0;
        w_wptr_nxt        = r_wptr;
        w_rptr_nxt        = r_rptr;
        w_count_nxt       = r_count;

        if (i_jump_en) begin
            w_fetch_pc_nxt = w_jump_target;
            w_wptr_nxt     = '0;
            w_rptr_nxt     = '0;
            w_count_nxt    = '0;
        end else begin
            if (w_ren) begin
                w_fetch_pc_nxt    = r_fetch_pc + PC_W'(4);
                w_inflight_pc_nxt = r_fetch_pc;
                w_inflight_nxt    = 1'b1;
            end
            if (w_push) begin
                w_wptr_nxt = r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rptr_nxt = r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_inflight_pc <= w_inflight_pc_nxt;
            r_inflight    <= w_inflight_nxt;
            r_wptr        <= w_wptr_nxt;
            r_rptr        <= w_rptr_nxt;
            r_count       <= w_count_nxt;
        end
    end

    // Entry storage; written only when a live response returns
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_pc_mem[r_wptr]  <= r_inflight_pc;
            r_ins_mem[r_wptr] <= i_instr_dina;
        end
    end

    // Memory strobe and queue head presentation; NOP/zero PC while empty
    always_comb begin
        o_instr_ren   = w_ren;
        o_instr_raddr = r_fetch_pc;
        o_valid       = w_nonempty;
        o_count       = r_count;
        o_instr       = w_nonempty ? r_ins_mem[r_rptr] : NOP_INSTR;
        o_pc          = w_nonempty ? r_pc_mem[r_rptr] : '0;
    end

endmodule
